judge_score_core: RTL and testbench
===================================

Name: judge_score_core

Overview:
- Parametrised multi-track successor to the current two-track judgement and scoring path.
- Per track: timing window opened by the note-arrival pulse from the LCD/track renderer; button press graded PERFECT/GOOD, expiry graded MISS.
- Results serialised onto one judgement bus; score and combo/max-combo accumulated in-block.
- Adds a game-phase FSM (IDLE/PLAY/END) gating all judging; feeds score, LED and segment controllers.

Parameters:
- N_TRACK, 4: number of tracks, ≥1.
- WIN_PERFECT, 30: PERFECT window in ticks (ms); 1 ≤ WIN_PERFECT ≤ WIN_GOOD.
- WIN_GOOD, 80: total window in ticks; ≥1.
- SCORE_PERFECT, 2: points per PERFECT.
- SCORE_GOOD, 1: points per GOOD.
- SCORE_W, 16: score width.
- COMBO_W, 10: combo / max-combo width.

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  synchronous active-high reset
- i_tick  in  1  1 ms single-cycle tick
- i_start  in  1  start pulse, already debounced
- i_restart  in  1  restart pulse, already debounced
- i_game_end  in  1  chart-finished pulse
- i_hit  in  N_TRACK  per-track note-arrival pulse
- i_btn_play  in  N_TRACK  per-track press pulse, debounced, one cycle
- o_phase  out  2  0 IDLE, 1 PLAY, 2 END
- o_judge_valid  out  1  one-cycle strobe per judgement
- o_judge  out  2  0 none, 1 MISS, 2 GOOD, 3 PERFECT; holds the last value
- o_judge_track  out  clog2(N_TRACK) (min 1)  track of the last judgement
- o_score  out  SCORE_W  accumulated score
- o_combo  out  COMBO_W  current combo
- o_max_combo  out  COMBO_W  best combo this game

Behaviour:
- Reset: every output 0, phase IDLE, all windows closed, all pending slots empty.
- Phase FSM:
  - IDLE→PLAY on i_start; score, combo and max-combo clear on the same edge.
  - PLAY→END on i_game_end; open windows and pending slots are discarded and produce no MISS.
  - Any phase→IDLE on i_restart; clears score, combo, max-combo, o_judge, windows and pending slots. i_restart beats i_start and i_game_end in the same cycle.
  - Outside PLAY: i_hit, i_btn_play and i_tick are ignored by the tracks.
- Per-track window (PLAY only):
  - State is an open flag plus an elapsed counter of width clog2(WIN_GOOD+1).
  - i_hit opens the window with elapsed = 0.
  - i_tick increments elapsed while the window is open.
  - When elapsed would reach WIN_GOOD: window closes, MISS is produced.
- Press on an open window: grade is PERFECT if elapsed < WIN_PERFECT, otherwise GOOD; window closes.
- Press with no window open: ignored, no MISS, combo unchanged.
- Simultaneous events on one track:
  - Press + expiry tick: the press wins (graded on the pre-increment elapsed).
  - Press + i_hit with a window open: the press grades the old window; the new window opens at 0.
  - Press + i_hit with no window open: window opens and is graded PERFECT immediately.
  - i_hit with a window open and no press: old window yields MISS; new window opens at 0.
- Pending slot: one 2-bit slot per track, written on the edge after the event.
  - Per-track events are ≥1 tick apart except the cases above, so a slot never holds two results.
  - A write into an occupied slot overwrites it; verification asserts this never occurs.
- Output arbiter: each cycle the lowest-index occupied slot is registered to o_judge/o_judge_track with o_judge_valid = 1, and that slot clears.
  - Uncontended latency: o_judge_valid 2 clocks after the event cycle.
  - Worst case: N_TRACK+1 clocks.
- Accumulate on the o_judge_valid cycle; values update one clock later.
  - PERFECT / GOOD: score += SCORE_PERFECT / SCORE_GOOD, saturating at 2^SCORE_W−1. Combo += 1, saturating. max_combo = max(max_combo, new combo).
  - MISS: combo = 0; score and max_combo unchanged.

Test Plan:
- Reset, i_start, then i_hit[0] and a press on track 0 after 10 ticks → o_judge=3, track 0, valid 2 clocks after the press; o_score=2, o_combo=1.
- i_hit[1], press after 50 ticks → GOOD, score +1. Separately, i_hit[2] with no press → MISS exactly on the 80th tick (+2 clocks), combo 0, max_combo retained.
- i_hit[3] and i_btn_play[3] in the same cycle → PERFECT. Re-hit track 3 at tick 40 with no press → MISS for the old note; the new window then grades independently.
- All 4 tracks pressed in the same cycle on open windows → four valid strobes on consecutive clocks, tracks 0,1,2,3; score +8.
- Score preloaded near saturation with SCORE_W=4: three PERFECTs → o_score sticks at 15. Stray press with no window → no strobe.
- i_game_end with 2 windows open → phase END, no MISS strobes. i_restart with i_start in the same cycle → IDLE, all counters 0.

Source files
------------

// File: rtl/judge_score_core_if.sv
// -----------------------------------------------------------------------------
// judge_score_core_if
// Judgement bus carrying one graded result per strobe from the judging core
// to its consumers (score, LED and segment controllers).
//   judge_valid  one-cycle strobe per judgement
//   judge        0 none, 1 MISS, 2 GOOD, 3 PERFECT; holds the last value
//   judge_track  track index of the last judgement
// TRACK_W must equal the core's track-index width, max(1, clog2(N_TRACK)).
// master: driven by judge_score_core; slave: read by consumers.
// -----------------------------------------------------------------------------
interface judge_score_core_if #(
    parameter int TRACK_W = 2
);
    logic               judge_valid;
    logic [1:0]         judge;
    logic [TRACK_W-1:0] judge_track;

    modport master (
        output judge_valid,
        output judge,
        output judge_track
    );

    modport slave (
        input judge_valid,
        input judge,
        input judge_track
    );
endinterface

// File: rtl/judge_score_core.sv
// -----------------------------------------------------------------------------
// judge_score_core
// Multi-track rhythm-game judging.
//
// Each track runs a timing window that is opened by a note-arrival pulse.
// A button press on an open window is graded PERFECT or GOOD from the elapsed
// tick count, and a window that runs out is graded MISS. Results go into one
// pending slot per track; an arbiter drains the lowest occupied slot each
// cycle onto the judgement bus. Score, combo and max-combo accumulate from
// the bus. A phase FSM (IDLE/PLAY/END) gates all judging.
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   i_tick          1 ms single-cycle tick
//   i_start         IDLE -> PLAY, clears score/combo/max-combo
//   i_restart       any phase -> IDLE, clears everything (highest priority)
//   i_game_end      PLAY -> END, discards open windows and pending results
//   i_hit           per-track note-arrival pulse
//   i_btn_play      per-track press pulse
//   o_phase         0 IDLE, 1 PLAY, 2 END
//   jbus            judgement bus (valid / judge / track)
//   o_score         accumulated score, saturating
//   o_combo         current combo, saturating
//   o_max_combo     best combo this game
// -----------------------------------------------------------------------------
module judge_score_core #(
    parameter int N_TRACK       = 4,
    parameter int WIN_PERFECT   = 30,
    parameter int WIN_GOOD      = 80,
    parameter int SCORE_PERFECT = 2,
    parameter int SCORE_GOOD    = 1,
    parameter int SCORE_W       = 16,
    parameter int COMBO_W       = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_tick,
    input  logic                    i_start,
    input  logic                    i_restart,
    input  logic                    i_game_end,
    input  logic [N_TRACK-1:0]      i_hit,
    input  logic [N_TRACK-1:0]      i_btn_play,
    output logic [1:0]              o_phase,
    judge_score_core_if.master      jbus,
    output logic [SCORE_W-1:0]      o_score,
    output logic [COMBO_W-1:0]      o_combo,
    output logic [COMBO_W-1:0]      o_max_combo
);
    localparam int TRACK_W = (N_TRACK > 1) ? $clog2(N_TRACK) : 1;
    localparam int ELAP_W  = $clog2(WIN_GOOD + 1);

    localparam logic [ELAP_W-1:0]  PERF_LIM  = ELAP_W'(WIN_PERFECT);
    localparam logic [ELAP_W-1:0]  GOOD_LAST = ELAP_W'(WIN_GOOD - 1);
    localparam logic [SCORE_W:0]   P_INC     = (SCORE_W + 1)'(SCORE_PERFECT);
    localparam logic [SCORE_W:0]   G_INC     = (SCORE_W + 1)'(SCORE_GOOD);

    localparam logic [1:0] J_NONE    = 2'd0;
    localparam logic [1:0] J_MISS    = 2'd1;
    localparam logic [1:0] J_GOOD    = 2'd2;
    localparam logic [1:0] J_PERFECT = 2'd3;

    typedef enum logic [1:0] {
        PH_IDLE = 2'd0,
        PH_PLAY = 2'd1,
        PH_END  = 2'd2
    } phase_t;

    phase_t phase_q;

    logic play;
    logic flush;

    // Window/slot state is dropped on restart, and on leaving PLAY for END.
    assign play  = (phase_q == PH_PLAY);
    assign flush = i_restart | (play & i_game_end);

    // ------------------------------------------------------------ phase FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= PH_IDLE;
        end else if (i_restart) begin
            phase_q <= PH_IDLE;
        end else begin
            case (phase_q)
                PH_IDLE: if (i_start)    phase_q <= PH_PLAY;
                PH_PLAY: if (i_game_end) phase_q <= PH_END;
                PH_END:  phase_q <= PH_END;
                default: phase_q <= PH_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------ tracks
    logic [1:0]         pend_arr [N_TRACK];
    logic [N_TRACK-1:0] grant;

    for (genvar gi = 0; gi < N_TRACK; gi++) begin : g_trk
        logic              open_q, open_d;
        logic [ELAP_W-1:0] elap_q, elap_d;
        logic [1:0]        pend_q, pend_d;
        logic [1:0]        grade;

        always_comb begin
            open_d = open_q;
            elap_d = elap_q;
            grade  = J_NONE;
            if (play) begin
                if (i_btn_play[gi] && open_q) begin
                    // Press grades the pre-increment elapsed; a same-cycle
                    // hit starts the next note's window.
                    grade  = (elap_q < PERF_LIM) ? J_PERFECT : J_GOOD;
                    open_d = i_hit[gi];
                    elap_d = '0;
                end else if (i_btn_play[gi] && i_hit[gi]) begin
                    // Note and press coincide: elapsed 0 is always PERFECT.
                    grade  = J_PERFECT;
                    open_d = 1'b0;
                    elap_d = '0;
                end else if (i_hit[gi]) begin
                    if (open_q) grade = J_MISS;
                    open_d = 1'b1;
                    elap_d = '0;
                end else if (i_tick && open_q) begin
                    if (elap_q == GOOD_LAST) begin
                        grade  = J_MISS;
                        open_d = 1'b0;
                        elap_d = '0;
                    end else begin
                        elap_d = elap_q + 1'b1;
                    end
                end
            end

            // A fresh result takes precedence over the slot being drained.
            pend_d = pend_q;
            if (grant[gi])       pend_d = J_NONE;
            if (grade != J_NONE) pend_d = grade;

            if (flush) begin
                open_d = 1'b0;
                elap_d = '0;
                pend_d = J_NONE;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                open_q <= 1'b0;
                elap_q <= '0;
                pend_q <= J_NONE;
            end else begin
                open_q <= open_d;
                elap_q <= elap_d;
                pend_q <= pend_d;
            end
        end

        assign pend_arr[gi] = pend_q;

        a_no_overwrite: assert property (@(posedge clk) disable iff (rst)
            !(!flush && grade != J_NONE && pend_q != J_NONE && !grant[gi]));
    end

    // ------------------------------------------------------------ arbiter
    logic               sel_valid;
    logic [1:0]         sel_judge;
    logic [TRACK_W-1:0] sel_track;

    always_comb begin
        grant     = '0;
        sel_valid = 1'b0;
        sel_judge = J_NONE;
        sel_track = '0;
        for (int i = 0; i < N_TRACK; i++) begin
            if (!sel_valid && pend_arr[i] != J_NONE) begin
                sel_valid = 1'b1;
                grant[i]  = 1'b1;
                sel_judge = pend_arr[i];
                sel_track = TRACK_W'(i);
            end
        end
    end

    // ------------------------------------------------------------ accumulate
    logic               judge_valid_q;
    logic [1:0]         judge_q;
    logic [TRACK_W-1:0] judge_track_q;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [COMBO_W-1:0] combo_q, combo_d, max_combo_q, max_combo_d;
    logic [SCORE_W:0]   score_sum;

    always_comb begin
        score_d     = score_q;
        combo_d     = combo_q;
        max_combo_d = max_combo_q;
        score_sum   = {1'b0, score_q} + ((judge_q == J_PERFECT) ? P_INC : G_INC);
        if (judge_valid_q) begin
            if (judge_q == J_MISS) begin
                combo_d = '0;
            end else if (judge_q != J_NONE) begin
                score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
                combo_d = (combo_q == '1) ? combo_q : combo_q + 1'b1;
                if (combo_d > max_combo_q) max_combo_d = combo_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            judge_valid_q <= 1'b0;
            judge_q       <= J_NONE;
            judge_track_q <= '0;
            score_q       <= '0;
            combo_q       <= '0;
            max_combo_q   <= '0;
        end else begin
            judge_valid_q <= sel_valid & ~flush;
            if (i_restart) begin
                judge_q       <= J_NONE;
                judge_track_q <= '0;
            end else if (sel_valid && !flush) begin
                judge_q       <= sel_judge;
                judge_track_q <= sel_track;
            end

            if (i_restart || (phase_q == PH_IDLE && i_start)) begin
                score_q     <= '0;
                combo_q     <= '0;
                max_combo_q <= '0;
            end else begin
                score_q     <= score_d;
                combo_q     <= combo_d;
                max_combo_q <= max_combo_d;
            end
        end
    end

    assign o_phase          = phase_q;
    assign jbus.judge_valid = judge_valid_q;
    assign jbus.judge       = judge_q;
    assign jbus.judge_track = judge_track_q;
    assign o_score          = score_q;
    assign o_combo          = combo_q;
    assign o_max_combo      = max_combo_q;
endmodule

// File: tb/tb_judge_score_core.sv
// -----------------------------------------------------------------------------
// tb_judge_score_core
// Directed bench for judge_score_core. A default-parameter instance covers
// grading, expiry, re-hit, arbitration, stray presses and phase control; a
// SCORE_W=4 instance covers score saturation.
// -----------------------------------------------------------------------------
module tb_judge_score_core;
    logic       clk = 1'b0;
    logic       rst;
    logic       tick, start, restart, gend;
    logic [3:0] hit, btn, hit2, btn2;

    logic [1:0]  phase, phase2;
    logic [15:0] score;
    logic [3:0]  score2;
    logic [9:0]  combo, max_combo, combo2, max_combo2;

    int n_checks = 0;
    int n_pass   = 0;
    int strobes  = 0;
    int s0;

    always #10 clk = ~clk;

    judge_score_core_if #(.TRACK_W(2)) jif ();
    judge_score_core_if #(.TRACK_W(2)) jif2 ();

    judge_score_core dut (
        .clk(clk), .rst(rst), .i_tick(tick), .i_start(start),
        .i_restart(restart), .i_game_end(gend), .i_hit(hit),
        .i_btn_play(btn), .o_phase(phase), .jbus(jif.master),
        .o_score(score), .o_combo(combo), .o_max_combo(max_combo)
    );

    judge_score_core #(.SCORE_W(4)) dut2 (
        .clk(clk), .rst(rst), .i_tick(tick), .i_start(start),
        .i_restart(restart), .i_game_end(gend), .i_hit(hit2),
        .i_btn_play(btn2), .o_phase(phase2), .jbus(jif2.master),
        .o_score(score2), .o_combo(combo2), .o_max_combo(max_combo2)
    );

    always @(negedge clk) if (jif.judge_valid) strobes++;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        $display("check %-14s got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int k = 0; k < n; k++) begin
            tick = 1'b1; step();
            tick = 1'b0; step();
        end
    endtask

    task automatic fire(input logic [3:0] h, input logic [3:0] b);
        hit = h; btn = b;
        step();
        hit = '0; btn = '0;
    endtask

    // Called right after the event edge: no strobe yet, strobe one edge later.
    task automatic expect_strobe(input string tag, input int j, input int t);
        chk({tag, "_pre"}, int'(jif.judge_valid), 0);
        step();
        chk({tag, "_v"}, int'(jif.judge_valid), 1);
        chk({tag, "_j"}, int'(jif.judge), j);
        chk({tag, "_t"}, int'(jif.judge_track), t);
    endtask

    initial begin
        rst = 1'b1; tick = 0; start = 0; restart = 0; gend = 0;
        hit = '0; btn = '0; hit2 = '0; btn2 = '0;
        step(); step(); step();
        rst = 1'b0;
        step();

        chk("rst_phase", int'(phase), 0);
        chk("rst_valid", int'(jif.judge_valid), 0);
        chk("rst_judge", int'(jif.judge), 0);
        chk("rst_track", int'(jif.judge_track), 0);
        chk("rst_score", int'(score), 0);
        chk("rst_combo", int'(combo), 0);
        chk("rst_max", int'(max_combo), 0);

        start = 1'b1; step(); start = 1'b0;
        chk("start_phase", int'(phase), 1);
        chk("start_phase2", int'(phase2), 1);

        // Track 0: press after 10 ticks -> PERFECT
        fire(4'b0001, 4'b0000);
        tick_n(10);
        fire(4'b0000, 4'b0001);
        expect_strobe("t0_perf", 3, 0);
        step();
        chk("t0_score", int'(score), 2);
        chk("t0_combo", int'(combo), 1);
        chk("t0_max", int'(max_combo), 1);

        // Track 1: press after 50 ticks -> GOOD
        fire(4'b0010, 4'b0000);
        tick_n(50);
        fire(4'b0000, 4'b0010);
        expect_strobe("t1_good", 2, 1);
        step();
        chk("t1_score", int'(score), 3);
        chk("t1_combo", int'(combo), 2);

        // Track 2: no press -> MISS exactly on the 80th tick
        s0 = strobes;
        fire(4'b0100, 4'b0000);
        tick_n(79);
        chk("t2_no_early", strobes - s0, 0);
        tick = 1'b1; step(); tick = 1'b0;
        expect_strobe("t2_miss", 1, 2);
        step();
        chk("t2_combo", int'(combo), 0);
        chk("t2_max", int'(max_combo), 2);
        chk("t2_score", int'(score), 3);

        // Track 3: hit and press in the same cycle -> PERFECT
        fire(4'b1000, 4'b1000);
        expect_strobe("t3_same", 3, 3);
        step();
        chk("t3_score", int'(score), 5);

        // Re-hit at tick 40 -> MISS for the old note, new window separate
        fire(4'b1000, 4'b0000);
        tick_n(40);
        fire(4'b1000, 4'b0000);
        expect_strobe("t3_rehit", 1, 3);
        step();
        chk("rehit_combo", int'(combo), 0);
        tick_n(5);
        fire(4'b0000, 4'b1000);
        expect_strobe("t3_new", 3, 3);
        step();
        chk("new_score", int'(score), 7);
        chk("new_combo", int'(combo), 1);

        // All four pressed together -> strobes on consecutive clocks
        fire(4'b1111, 4'b0000);
        tick_n(3);
        fire(4'b0000, 4'b1111);
        expect_strobe("all_0", 3, 0);
        step();
        chk("all_1_v", int'(jif.judge_valid), 1);
        chk("all_1_t", int'(jif.judge_track), 1);
        step();
        chk("all_2_v", int'(jif.judge_valid), 1);
        chk("all_2_t", int'(jif.judge_track), 2);
        step();
        chk("all_3_v", int'(jif.judge_valid), 1);
        chk("all_3_t", int'(jif.judge_track), 3);
        step();
        chk("all_end_v", int'(jif.judge_valid), 0);
        chk("all_score", int'(score), 15);
        chk("all_combo", int'(combo), 5);
        chk("all_max", int'(max_combo), 5);

        // Stray press with no window open
        s0 = strobes;
        fire(4'b0000, 4'b0001);
        step(); step();
        chk("stray_strobe", strobes - s0, 0);
        chk("stray_combo", int'(combo), 5);

        // Saturation on the SCORE_W=4 instance: 8 -> 12 -> 14,15,15
        hit2 = 4'b1111; btn2 = 4'b1111; step(); hit2 = '0; btn2 = '0;
        for (int k = 0; k < 6; k++) step();
        chk("sat_8", int'(score2), 8);
        hit2 = 4'b0011; btn2 = 4'b0011; step(); hit2 = '0; btn2 = '0;
        for (int k = 0; k < 6; k++) step();
        chk("sat_12", int'(score2), 12);
        hit2 = 4'b0111; btn2 = 4'b0111; step(); hit2 = '0; btn2 = '0;
        for (int k = 0; k < 6; k++) step();
        chk("sat_15", int'(score2), 15);
        chk("sat_combo", int'(combo2), 9);
        chk("sat_max", int'(max_combo2), 9);

        // Game end with two windows open -> END, no MISS strobes
        fire(4'b0011, 4'b0000);
        tick_n(2);
        gend = 1'b1; step(); gend = 1'b0;
        chk("end_phase", int'(phase), 2);
        s0 = strobes;
        tick_n(85);
        fire(4'b0000, 4'b0001);
        step(); step();
        chk("end_no_miss", strobes - s0, 0);
        chk("end_score", int'(score), 15);

        // Restart beats start in the same cycle
        restart = 1'b1; start = 1'b1; step(); restart = 1'b0; start = 1'b0;
        chk("rs_phase", int'(phase), 0);
        chk("rs_score", int'(score), 0);
        chk("rs_combo", int'(combo), 0);
        chk("rs_max", int'(max_combo), 0);
        chk("rs_judge", int'(jif.judge), 0);
        chk("rs_score2", int'(score2), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
